// File: rtl/uart_pkg.sv
// Shared definitions for the UART register controller: bus widths, register
// address map, status/command bit positions and the access-FSM state type.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        REG_STAT = 2'd0,
        REG_MASK = 2'd1,
        REG_DATA = 2'd2,
        REG_BAUD = 2'd3
    } reg_addr_e;

    // Status register bit positions
    localparam int unsigned ST_TXE  = 0;
    localparam int unsigned ST_RXF  = 1;
    localparam int unsigned ST_OVR  = 2;
    localparam int unsigned ST_FE   = 3;
    localparam int unsigned ST_TOVR = 4;
    localparam int unsigned ST_CRCE = 5;

    // Command bits written to the status address
    localparam int unsigned CMD_FLUSH   = 0;
    localparam int unsigned CMD_DISCARD = 1;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_ACT  = 2'd1,
        ACC_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/uart_access_fsm.sv
// CPU access sequencer: turns one chip-select assertion into exactly one
// single-cycle read or write strobe and keeps the read-drive window open
// until chip select is released.
//   clk, rst_n     : clock, async active-low reset
//   ncs, no, nw    : CPU chip select / read enable / write enable (active low)
//   act_rd, act_wr : one-cycle strobes, high during the ACT state
//   drive_en       : read data may be driven (cycle after ACT through HOLD)
module uart_access_fsm
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ncs,
    input  logic no,
    input  logic nw,
    output logic act_rd,
    output logic act_wr,
    output logic drive_en
);

    acc_state_e state_q, state_d;
    logic       rd_q, rd_d;
    logic       act_rd_q, act_rd_d;
    logic       act_wr_q, act_wr_d;
    logic       drive_en_q, drive_en_d;

    // Next state; NO=NW=0 (both strobes) is rejected by the XOR
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        act_rd_d   = 1'b0;
        act_wr_d   = 1'b0;
        drive_en_d = 1'b0;
        case (state_q)
            ACC_IDLE: begin
                if (!ncs && (no ^ nw)) begin
                    state_d  = ACC_ACT;
                    rd_d     = !no;
                    act_rd_d = !no;
                    act_wr_d = no;
                end
            end
            ACC_ACT: begin
                state_d    = ACC_HOLD;
                drive_en_d = rd_q;
            end
            ACC_HOLD: begin
                if (ncs) begin
                    state_d = ACC_IDLE;
                end else begin
                    drive_en_d = rd_q;
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC_IDLE;
            rd_q       <= 1'b0;
            act_rd_q   <= 1'b0;
            act_wr_q   <= 1'b0;
            drive_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            act_rd_q   <= act_rd_d;
            act_wr_q   <= act_wr_d;
            drive_en_q <= drive_en_d;
        end
    end

    assign act_rd   = act_rd_q;
    assign act_wr   = act_wr_q;
    assign drive_en = drive_en_q;

endmodule

// File: rtl/uart_regctl.sv
// UART register file and sequencing controller between the CPU bus and the
// serial TX/RX engines. Optional feature macro: UART_CRC_EN (CRC error status
// bit 5 and its interrupt contribution).
//   CLK, NRST                   : clock, async active-low reset
//   ADDR, NCS, NO, NW, DATA     : CPU bus (DATA driven only during reads)
//   NINT                        : active-low interrupt
//   tx_data, tx_start, tx_busy  : transmitter handshake
//   rx_data, rx_valid, rx_ferr  : receiver byte intake
//   crc_err                     : CRC mismatch pulse
//   baud_div                    : baud divisor, never 0
module uart_regctl
    import uart_pkg::*;
#(
    parameter logic [DATA_W-1:0] DIV_RESET = 8'd16
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              NCS,
    input  logic              NO,
    input  logic              NW,
    inout  wire  [DATA_W-1:0] DATA,
    output logic              NINT,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    input  logic              crc_err,
    output logic [DATA_W-1:0] baud_div
);

    logic [DATA_W-1:0] st_q, st_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] baud_q, baud_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              tx_start_q, tx_start_d;
    logic              nint_q, nint_d;
    logic              rx_clr;
    logic              act_rd, act_wr, drive_en;
    reg_addr_e         addr_c;

    assign addr_c = reg_addr_e'(ADDR);

    uart_access_fsm u_fsm (
        .clk      (CLK),
        .rst_n    (NRST),
        .ncs      (NCS),
        .no       (NO),
        .nw       (NW),
        .act_rd   (act_rd),
        .act_wr   (act_wr),
        .drive_en (drive_en)
    );

`ifndef UART_CRC_EN
    logic unused_crc;
    assign unused_crc = crc_err;
`endif

    // Register side effects; clears are applied before sets so sets win
    always_comb begin
        st_d       = st_q;
        mask_d     = mask_q;
        rx_byte_d  = rx_byte_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        baud_d     = baud_q;
        rd_data_d  = rd_data_q;
        tx_start_d = 1'b0;
        rx_clr     = 1'b0;

        if (act_rd) begin
            case (addr_c)
                REG_STAT: begin
                    rd_data_d        = st_q;
                    st_d[ST_OVR]     = 1'b0;
                    st_d[ST_FE]      = 1'b0;
                    st_d[ST_TOVR]    = 1'b0;
                    st_d[ST_CRCE]    = 1'b0;
                end
                REG_MASK: rd_data_d = mask_q;
                REG_DATA: begin
                    rd_data_d    = rx_byte_q;
                    st_d[ST_RXF] = 1'b0;
                    rx_clr       = 1'b1;
                end
                REG_BAUD: rd_data_d = baud_q;
            endcase
        end

        if (act_wr) begin
            case (addr_c)
                REG_STAT: begin
                    if (DATA[CMD_FLUSH]) begin
                        st_d[ST_TXE] = 1'b1;
                    end
                    if (DATA[CMD_DISCARD]) begin
                        st_d[ST_RXF] = 1'b0;
                        rx_clr       = 1'b1;
                    end
                end
                REG_MASK: mask_d = DATA;
                REG_DATA: begin
                    if (st_q[ST_TXE]) begin
                        hold_d       = DATA;
                        st_d[ST_TXE] = 1'b0;
                    end else begin
                        st_d[ST_TOVR] = 1'b1;
                    end
                end
                REG_BAUD: baud_d = (DATA == '0) ? DATA_W'(1) : DATA;
            endcase
        end

        // TX launch; a back-to-back start is blocked until tx_busy can respond
        if (!st_q[ST_TXE] && !tx_busy && !tx_start_q) begin
            tx_start_d   = 1'b1;
            tx_data_d    = hold_q;
            st_d[ST_TXE] = 1'b1;
        end

        // RX intake; a byte being read out this cycle frees the slot
        if (rx_valid) begin
            if (!st_q[ST_RXF] || rx_clr) begin
                rx_byte_d    = rx_data;
                st_d[ST_RXF] = 1'b1;
                st_d[ST_FE]  = rx_ferr;
            end else begin
                st_d[ST_OVR] = 1'b1;
            end
        end

`ifdef UART_CRC_EN
        if (crc_err) begin
            st_d[ST_CRCE] = 1'b1;
        end
`else
        st_d[ST_CRCE] = 1'b0;
`endif
        st_d[DATA_W-1:ST_CRCE+1] = '0;

        nint_d = ~|(st_q & mask_q);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            st_q       <= DATA_W'(1);
            mask_q     <= '0;
            rx_byte_q  <= '0;
            hold_q     <= '0;
            tx_data_q  <= '0;
            baud_q     <= DIV_RESET;
            rd_data_q  <= '0;
            tx_start_q <= 1'b0;
            nint_q     <= 1'b1;
        end else begin
            st_q       <= st_d;
            mask_q     <= mask_d;
            rx_byte_q  <= rx_byte_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            baud_q     <= baud_d;
            rd_data_q  <= rd_data_d;
            tx_start_q <= tx_start_d;
            nint_q     <= nint_d;
        end
    end

    // Drive window also gated by the live strobes so release is immediate
    assign DATA     = (drive_en && !NCS && !NO) ? rd_data_q : 'z;
    assign NINT     = nint_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign baud_div = baud_q;

endmodule

// File: tb/tb_uart_regctl.sv
// Self-checking bench for uart_regctl: register table plus directed sequences.
module tb_uart_regctl;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       NRST;
    logic [1:0] ADDR;
    logic       NCS, NO, NW;
    wire  [7:0] DATA;
    logic       NINT;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, crc_err;
    logic [7:0] baud_div;

    logic       bus_oe;
    logic [7:0] bus_drv;
    assign DATA = bus_oe ? bus_drv : 'z;

    uart_regctl dut (
        .CLK      (CLK),
        .NRST     (NRST),
        .ADDR     (ADDR),
        .NCS      (NCS),
        .NO       (NO),
        .NW       (NW),
        .DATA     (DATA),
        .NINT     (NINT),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .crc_err  (crc_err),
        .baud_div (baud_div)
    );

    always #5 CLK = ~CLK;

    // Simple TX engine: busy for busy_len cycles starting the cycle after tx_start
    int         busy_len = 12;
    int         busy_cnt;
    int         tx_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    assign tx_busy = (busy_cnt != 0);

    always @(posedge CLK or negedge NRST) begin
        if (!NRST)               busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= busy_len;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end

    always @(posedge CLK) begin
        if (tx_start) begin
            tx_cnt  <= tx_cnt + 1;
            last_tx <= tx_data;
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        ADDR = a; NCS = 1'b0; NW = 1'b0; bus_drv = d; bus_oe = 1'b1;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        NCS = 1'b1; NW = 1'b1; bus_oe = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge CLK); #1;
        ADDR = a; NCS = 1'b0; NO = 1'b0;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        d = DATA;
        NCS = 1'b1; NO = 1'b1;
    endtask

    task automatic rx_push(input logic [7:0] b, input logic fe);
        @(posedge CLK); #1;
        rx_valid = 1'b1; rx_data = b; rx_ferr = fe;
        @(posedge CLK); #1;
        rx_valid = 1'b0; rx_ferr = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] a;
        logic [7:0] d;     // write data, or expected read data
        logic [7:0] baud;  // expected baud_div afterwards
    } vec_t;

    vec_t       vt [14];
    logic [7:0] rd;
    int         base;

    initial begin
        NRST = 1'b0; ADDR = 2'd0; NCS = 1'b1; NO = 1'b1; NW = 1'b1;
        bus_oe = 1'b0; bus_drv = 8'h00;
        rx_data = 8'h00; rx_valid = 1'b0; rx_ferr = 1'b0; crc_err = 1'b0;

        vt[0]  = '{1'b0, 2'd0, 8'h01, 8'h10};
        vt[1]  = '{1'b0, 2'd1, 8'h00, 8'h10};
        vt[2]  = '{1'b0, 2'd3, 8'h10, 8'h10};
        vt[3]  = '{1'b0, 2'd2, 8'h00, 8'h10};
        vt[4]  = '{1'b1, 2'd3, 8'h00, 8'h01};
        vt[5]  = '{1'b0, 2'd3, 8'h01, 8'h01};
        vt[6]  = '{1'b1, 2'd3, 8'h2B, 8'h2B};
        vt[7]  = '{1'b0, 2'd3, 8'h2B, 8'h2B};
        vt[8]  = '{1'b1, 2'd1, 8'hFF, 8'h2B};
        vt[9]  = '{1'b0, 2'd1, 8'hFF, 8'h2B};
        vt[10] = '{1'b1, 2'd1, 8'h00, 8'h2B};
        vt[11] = '{1'b1, 2'd0, 8'h02, 8'h2B};
        vt[12] = '{1'b0, 2'd0, 8'h01, 8'h2B};
        vt[13] = '{1'b0, 2'd1, 8'h00, 8'h2B};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_nint", 8'(NINT), 8'h01);
        check("rst_txstart", 8'(tx_start), 8'h00);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_baud", baud_div, 8'h10);
        @(posedge CLK); #1 NRST = 1'b1;

        // Register table
        foreach (vt[i]) begin
            if (vt[i].wr) begin
                cpu_write(vt[i].a, vt[i].d);
            end else begin
                cpu_read(vt[i].a, rd);
                check($sformatf("tbl%0d_rd", i), rd, vt[i].d);
            end
            check($sformatf("tbl%0d_baud", i), baud_div, vt[i].baud);
        end

        // TX launch timing and overrun of the holding register
        busy_len = 12;
        base = tx_cnt;
        cpu_write(2'd2, 8'hA5);
        check("tx_start_early", 8'(tx_start), 8'h00);
        @(negedge CLK);
        check("tx_start_pulse", 8'(tx_start), 8'h01);
        check("tx_data_a5", tx_data, 8'hA5);
        @(negedge CLK);
        check("tx_start_single", 8'(tx_start), 8'h00);
        cpu_write(2'd2, 8'h5A);
        cpu_write(2'd2, 8'hC3);
        repeat (20) @(negedge CLK);
        check("tx_count", 8'(tx_cnt - base), 8'h02);
        check("tx_last", last_tx, 8'h5A);
        cpu_read(2'd0, rd); check("tovr_set", rd, 8'h11);
        cpu_read(2'd0, rd); check("tovr_clr", rd, 8'h01);

        // RX overrun and framing error
        rx_push(8'h3C, 1'b0);
        rx_push(8'h77, 1'b0);
        cpu_read(2'd2, rd); check("ovr_data", rd, 8'h3C);
        cpu_read(2'd0, rd); check("ovr_stat", rd, 8'h05);
        cpu_read(2'd0, rd); check("ovr_clr", rd, 8'h01);
        rx_push(8'hA0, 1'b1);
        cpu_read(2'd0, rd); check("fe_stat", rd, 8'h0B);
        cpu_read(2'd2, rd); check("fe_data", rd, 8'hA0);
        cpu_read(2'd0, rd); check("fe_clr", rd, 8'h01);

        // Interrupt latency on RXF with mask 02
        cpu_write(2'd1, 8'h02);
        check("nint_idle", 8'(NINT), 8'h01);
        @(posedge CLK); #1 rx_valid = 1'b1; rx_data = 8'h5E;
        @(posedge CLK); #1 rx_valid = 1'b0;
        @(negedge CLK); check("nint_lag", 8'(NINT), 8'h01);
        @(negedge CLK); check("nint_low", 8'(NINT), 8'h00);
        cpu_read(2'd2, rd); check("nint_data", rd, 8'h5E);
        check("nint_still_low", 8'(NINT), 8'h00);
        @(negedge CLK); check("nint_rise", 8'(NINT), 8'h01);
        cpu_write(2'd1, 8'h00);

        // Long chip select: one side effect, stable data, new byte survives
        rx_push(8'h96, 1'b0);
        @(posedge CLK); #1 ADDR = 2'd2; NCS = 1'b0; NO = 1'b0;
        @(posedge CLK); @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("hold_data%0d", i), DATA, 8'h96);
            if (i == 2) begin rx_valid = 1'b1; rx_data = 8'h44; end
            if (i == 3) rx_valid = 1'b0;
        end
        NCS = 1'b1; NO = 1'b1;
        cpu_read(2'd0, rd); check("hold_stat", rd, 8'h03);
        cpu_read(2'd2, rd); check("hold_next", rd, 8'h44);

        // Data read in ACT coinciding with rx_valid
        rx_push(8'h12, 1'b0);
        @(posedge CLK); #1 ADDR = 2'd2; NCS = 1'b0; NO = 1'b0;
        @(posedge CLK); #1 rx_valid = 1'b1; rx_data = 8'h34;
        @(posedge CLK); #1 rx_valid = 1'b0;
        @(negedge CLK); check("sim_old", DATA, 8'h12);
        NCS = 1'b1; NO = 1'b1;
        cpu_read(2'd0, rd); check("sim_stat", rd, 8'h03);
        cpu_read(2'd2, rd); check("sim_new", rd, 8'h34);

        // Illegal NO=NW=0: a discard command must not take effect
        rx_push(8'h11, 1'b0);
        @(posedge CLK); #1;
        ADDR = 2'd0; NCS = 1'b0; NO = 1'b0; NW = 1'b0; bus_oe = 1'b1; bus_drv = 8'h03;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("illegal_bus%0d", i), DATA, 8'h03);
        end
        NCS = 1'b1; NO = 1'b1; NW = 1'b1; bus_oe = 1'b0;
        cpu_read(2'd0, rd); check("illegal_stat", rd, 8'h03);
        cpu_read(2'd2, rd); check("illegal_data", rd, 8'h11);

        // CRC error status
        cpu_write(2'd1, 8'h20);
        @(posedge CLK); #1 crc_err = 1'b1;
        @(posedge CLK); #1 crc_err = 1'b0;
        @(negedge CLK); @(negedge CLK);
`ifdef UART_CRC_EN
        check("crc_nint", 8'(NINT), 8'h00);
        cpu_read(2'd0, rd); check("crc_stat", rd, 8'h21);
`else
        check("crc_nint", 8'(NINT), 8'h01);
        cpu_read(2'd0, rd); check("crc_stat", rd, 8'h01);
`endif
        cpu_read(2'd0, rd); check("crc_clr", rd, 8'h01);
        cpu_write(2'd1, 8'h00);

        // Flush of a held byte while the transmitter is busy
        busy_len = 30;
        base = tx_cnt;
        cpu_write(2'd2, 8'h11);
        cpu_write(2'd2, 8'h22);
        cpu_write(2'd0, 8'h01);
        repeat (40) @(negedge CLK);
        check("flush_count", 8'(tx_cnt - base), 8'h01);
        check("flush_last", last_tx, 8'h11);
        cpu_read(2'd0, rd); check("flush_stat", rd, 8'h01);

        // Reset in the middle of a read
        cpu_write(2'd3, 8'h00);
        cpu_write(2'd1, 8'h01);
        @(negedge CLK);
        check("pre_rst_nint", 8'(NINT), 8'h00);
        @(posedge CLK); #1 ADDR = 2'd0; NCS = 1'b0; NO = 1'b0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK); check("pre_rst_drive", DATA, 8'h01);
        #2 NRST = 1'b0; bus_oe = 1'b1; bus_drv = 8'h00;
        #1;
        check("rst_release", DATA, 8'h00);
        check("rst_mid_nint", 8'(NINT), 8'h01);
        check("rst_mid_baud", baud_div, 8'h10);
        check("rst_mid_txdata", tx_data, 8'h00);
        NCS = 1'b1; NO = 1'b1; bus_oe = 1'b0;
        @(posedge CLK); #1 NRST = 1'b1;
        cpu_read(2'd0, rd); check("post_rst_stat", rd, 8'h01);
        cpu_read(2'd1, rd); check("post_rst_mask", rd, 8'h00);

        // Reset while a launch is pending drops the launch
        busy_len = 4;
        base = tx_cnt;
        cpu_write(2'd2, 8'h66);
        NRST = 1'b0;
        #1 check("rst_pending_start", 8'(tx_start), 8'h00);
        @(posedge CLK); #1 NRST = 1'b1;
        repeat (6) @(negedge CLK);
        check("rst_pending_count", 8'(tx_cnt - base), 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
